rect_hit_detector: RTL

Collision consumer for the falling-rectangle renderers. Samples each rectangle's pixel-enable and the player's pixel-enable during the raster scan, counts overlapping pixels per rectangle per frame, and commits hits at the frame boundary. It produces the per-rectangle `hit` pulses and the `allHit` flag that feed back into each rectangle's state machine. It sits between the rectangle/player pixel generators and the rectangle state machines, clocked with the VGA pixel logic.

---
 rtl/freeze_tag_pkg.sv | 9 +
 rtl/rect_hit_detector_overlap_counter.sv | 36 +++
 rtl/rect_hit_detector.sv | 123 ++++++++++++
 3 files changed

// File: rtl/freeze_tag_pkg.sv
// Shared constants for the freeze-tag collision logic.
package freeze_tag_pkg;

  localparam int unsigned OVL_W           = 8;
  localparam int unsigned HITCNT_W        = 4;
  localparam int unsigned DEF_NUM_RECTS   = 4;
  localparam int unsigned DEF_MIN_OVERLAP = 4;

endpackage

// File: rtl/rect_hit_detector_overlap_counter.sv
// Per-rectangle overlap pixel counter: saturating, synchronous clear,
// asynchronous active-high reset.
module overlap_counter
  import freeze_tag_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [OVL_W-1:0] count
);

  logic [OVL_W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise increment unless already at full scale.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + OVL_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rect_hit_detector.sv
// Collision consumer: counts rectangle/player overlap pixels per frame and
// commits hits at the frame pulse into a latched frozen mask.
// Optional feature macro: HIT_DEBOUNCE_EN (require two consecutive
// qualifying commits before a rectangle is hit).
module rect_hit_detector
  import freeze_tag_pkg::*;
#(
  parameter int unsigned NUM_RECTS   = DEF_NUM_RECTS,
  parameter int unsigned MIN_OVERLAP = DEF_MIN_OVERLAP
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame,
  input  logic [NUM_RECTS-1:0]  rectPix,
  input  logic [NUM_RECTS-1:0]  activeRed,
  input  logic                  playerPix,
  input  logic                  clearHits,
  output logic [NUM_RECTS-1:0]  hit,
  output logic [NUM_RECTS-1:0]  frozen,
  output logic                  allHit,
  output logic [HITCNT_W-1:0]   hitCount
);

  logic [NUM_RECTS-1:0] inc;
  logic [NUM_RECTS-1:0] qualified;
  logic [NUM_RECTS-1:0] cand;
  logic [NUM_RECTS-1:0] new_hits;
  logic [NUM_RECTS-1:0] hit_q, hit_d;
  logic [NUM_RECTS-1:0] frozen_q, frozen_d;
  logic                 allHit_q, allHit_d;
  logic [HITCNT_W-1:0]  hitCount_q, hitCount_d;
  logic [OVL_W-1:0]     ovl [NUM_RECTS];
  logic                 ovl_clr;

  // Counters restart at every commit point and on a round clear.
  assign ovl_clr = frame | clearHits;

  // The threshold test adds the current-cycle pixel so overlap sampled in the
  // frame cycle itself is part of that commit; the extra bit avoids overflow.
  for (genvar i = 0; i < NUM_RECTS; i++) begin : g_rect
    assign inc[i] = rectPix[i] & playerPix;

    overlap_counter u_ovl (
      .clk   (clk),
      .reset (reset),
      .clr   (ovl_clr),
      .inc   (inc[i]),
      .count (ovl[i])
    );

    assign qualified[i] = (({1'b0, ovl[i]} + (OVL_W+1)'(inc[i])) >=
                           (OVL_W+1)'(MIN_OVERLAP));
  end

  assign cand = qualified & activeRed;

`ifdef HIT_DEBOUNCE_EN
  logic [NUM_RECTS-1:0] pending_q, pending_d;

  assign new_hits = cand & pending_q & ~frozen_q;

  // Pending tracks "qualified on the previous commit"; any commit that does
  // not qualify, and any clear, drops it.
  always_comb begin
    pending_d = pending_q;
    if (clearHits) begin
      pending_d = '0;
    end else if (frame) begin
      pending_d = cand & ~frozen_q;
    end
  end

  // Pending register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end
`else
  assign new_hits = cand & ~frozen_q;
`endif

  // Commit logic: clear has priority over frame; derived flags follow frozen_d.
  always_comb begin
    hit_d      = '0;
    frozen_d   = frozen_q;
    hitCount_d = '0;
    if (clearHits) begin
      frozen_d = '0;
    end else if (frame) begin
      hit_d    = new_hits;
      frozen_d = frozen_q | new_hits;
    end
    for (int unsigned i = 0; i < NUM_RECTS; i++) begin
      hitCount_d = hitCount_d + HITCNT_W'(frozen_d[i]);
    end
    allHit_d = &frozen_d;
  end

  // Output state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_q      <= '0;
      frozen_q   <= '0;
      allHit_q   <= 1'b0;
      hitCount_q <= '0;
    end else begin
      hit_q      <= hit_d;
      frozen_q   <= frozen_d;
      allHit_q   <= allHit_d;
      hitCount_q <= hitCount_d;
    end
  end

  assign hit      = hit_q;
  assign frozen   = frozen_q;
  assign allHit   = allHit_q;
  assign hitCount = hitCount_q;

endmodule
